// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix row packer and any reader of the packed rows:
// default geometry, the load-sequencer state type and the element lane placement.
package matrix_pkg;

    localparam int ELEM_W_DEF   = 8;
    localparam int MAX_ROWS_DEF = 32;
    localparam int MAX_COLS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Column 0 sits in the most significant lane of a packed row.
    function automatic int lane_lsb(input int col, input int max_cols, input int elem_w);
        return (max_cols - 1 - col) * elem_w;
    endfunction

endpackage

// File: rtl/matrix_row_packer.sv
// Gathers (row, col)-tagged matrix elements into full-width rows and writes
// each completed row to the matrix BRAM at the row's address.
module matrix_row_packer
    import matrix_pkg::*;
#(
    parameter int ELEM_W   = ELEM_W_DEF,
    parameter int MAX_ROWS = MAX_ROWS_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    localparam int RW  = $clog2(MAX_ROWS),
    localparam int CW  = $clog2(MAX_COLS),
    localparam int NRW = RW + 1,
    localparam int NCW = CW + 1,
    localparam int DW  = MAX_COLS * ELEM_W
) (
    input  logic              inter_refclk,
    input  logic              rst,
    input  logic              start,
    input  logic [NRW-1:0]    n_rows,
    input  logic [NCW-1:0]    n_cols,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RW-1:0]     row_addr,
    input  logic [CW-1:0]     col_addr,
    input  logic [ELEM_W-1:0] elem,
    output logic              wr_en,
    output logic [RW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [NRW-1:0] MAX_ROWS_V = NRW'(MAX_ROWS);
    localparam logic [NCW-1:0] MAX_COLS_V = NCW'(MAX_COLS);

    state_e            state_q;
    logic [NRW-1:0]    n_rows_q;
    logic [NCW-1:0]    n_cols_q;
    logic [RW-1:0]     cur_row_q;
    logic [DW-1:0]     buf_q;
    logic [DW-1:0]     buf_d;
    logic [MAX_COLS-1:0] mask_q;
    logic [MAX_COLS-1:0] mask_d;
    logic [NCW-1:0]    cnt_q;
    logic [NCW-1:0]    cnt_d;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [RW-1:0]     wr_addr_q;
    logic [DW-1:0]     wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic accept_s;
    logic hit_s;
    logic miss_s;
    logic row_full_s;
    logic last_row_s;
    logic cfg_bad_s;

    // Element classification, lane insertion and completion detection.
    always_comb begin
        accept_s = in_valid && in_ready_q;
        hit_s    = accept_s
                   && (row_addr == cur_row_q)
                   && ({1'b0, col_addr} < n_cols_q)
                   && !mask_q[col_addr];
        miss_s   = accept_s && !hit_s;
        buf_d    = buf_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        if (hit_s) begin
            buf_d[lane_lsb(int'(col_addr), MAX_COLS, ELEM_W) +: ELEM_W] = elem;
            mask_d[col_addr] = 1'b1;
            cnt_d            = cnt_q + NCW'(1);
        end else begin
            buf_d  = buf_q;
            mask_d = mask_q;
            cnt_d  = cnt_q;
        end
        // A hit can only raise the count, so the row is full the moment the count reaches n_cols.
        row_full_s = hit_s && (cnt_d == n_cols_q);
        last_row_s = ({1'b0, cur_row_q} == (n_rows_q - NRW'(1)));
        cfg_bad_s  = (n_rows == {NRW{1'b0}}) || (n_cols == {NCW{1'b0}})
                     || (n_rows > MAX_ROWS_V) || (n_cols > MAX_COLS_V);
    end

    // Load sequencer with registered handshake and BRAM write outputs.
    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_rows_q   <= {NRW{1'b0}};
            n_cols_q   <= {NCW{1'b0}};
            cur_row_q  <= {RW{1'b0}};
            buf_q      <= {DW{1'b0}};
            mask_q     <= {MAX_COLS{1'b0}};
            cnt_q      <= {NCW{1'b0}};
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {RW{1'b0}};
            wr_data_q  <= {DW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (cfg_bad_s) begin
                            err_q <= 1'b1;
                        end else begin
                            n_rows_q   <= n_rows;
                            n_cols_q   <= n_cols;
                            err_q      <= 1'b0;
                            cur_row_q  <= {RW{1'b0}};
                            buf_q      <= {DW{1'b0}};
                            mask_q     <= {MAX_COLS{1'b0}};
                            cnt_q      <= {NCW{1'b0}};
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (miss_s) begin
                        err_q <= 1'b1;
                    end
                    // The completing element is folded in directly so FLUSH presents the whole row.
                    if (row_full_s) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= cur_row_q;
                        wr_data_q  <= buf_d;
                        buf_q      <= {DW{1'b0}};
                        mask_q     <= {MAX_COLS{1'b0}};
                        cnt_q      <= {NCW{1'b0}};
                        in_ready_q <= 1'b0;
                        state_q    <= FLUSH;
                    end else begin
                        buf_q  <= buf_d;
                        mask_q <= mask_d;
                        cnt_q  <= cnt_d;
                    end
                end
                FLUSH: begin
                    wr_en_q <= 1'b0;
                    if (last_row_s) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cur_row_q  <= cur_row_q + RW'(1);
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_matrix_row_packer.sv
// Self-checking bench for matrix_row_packer: configuration table, directed
// multi-cycle sequences and randomized loads against a row-packing model.
module tb_matrix_row_packer;

    localparam int EW = 8;
    localparam int MR = 8;
    localparam int MC = 4;
    localparam int DW = MC * EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    n_rows = 4'd0;
    logic [2:0]    n_cols = 3'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    row_addr = 3'd0;
    logic [1:0]    col_addr = 2'd0;
    logic [7:0]    elem = 8'd0;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    matrix_row_packer #(.ELEM_W(EW), .MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .inter_refclk(clk), .rst(rst), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .in_valid(in_valid), .in_ready(in_ready), .row_addr(row_addr), .col_addr(col_addr),
        .elem(elem), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int flush_ready_viol = 0;
    int acc_cyc = 0;
    logic [2:0]    got_addr[$];
    logic [DW-1:0] got_data[$];
    int            got_cyc[$];

    typedef struct {
        logic [3:0] nr;
        logic [2:0] nc;
        logic       exp_err;
        logic       exp_busy;
        logic       rst_after;
    } cfg_vec_t;
    cfg_vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
            if (in_ready) flush_ready_viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic start_mat(input logic [3:0] nr, input logic [2:0] nc);
        start = 1'b1;
        n_rows = nr;
        n_cols = nc;
        tick();
        start = 1'b0;
    endtask

    // Leaves in_valid high so back-to-back calls keep the request asserted.
    task automatic send(input logic [2:0] r, input logic [1:0] c, input logic [7:0] v);
        int n;
        in_valid = 1'b1;
        row_addr = r;
        col_addr = c;
        elem = v;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end else begin
            acc_cyc = cyc;
            tick();
        end
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 50) begin
            tick();
            n++;
        end
        check("done_pulse_count", 64'(done_cnt), 64'(prev + 1));
        tick();
    endtask

    logic [7:0]    m[8][4];
    int            p[4];
    int            nr, nc, base, t, j, kind, pos, a0, a1;
    logic          inj, err_exp;
    logic [DW-1:0] exp_row;

    initial begin
        vecs[0] = '{4'd0,  3'd2, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'd3,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'd9,  3'd2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'd2,  3'd5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'd8,  3'd4, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{4'd15, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd1,  3'd1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", 64'({in_ready, wr_en, busy, done, err, wr_addr, wr_data}), 64'd0);
        rst = 1'b0;
        tick();

        // Configuration table: bad dimensions flag err and stay idle; good ones clear err.
        foreach (vecs[i]) begin
            start_mat(vecs[i].nr, vecs[i].nc);
            check($sformatf("cfg%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("cfg%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("cfg%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_busy));
            if (vecs[i].rst_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                tick();
            end
        end

        // 2x3 row-major load.
        clear_log();
        base = done_cnt;
        start_mat(4'd2, 3'd3);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) send(3'(r), 2'(c), 8'(8'h11 * (r * 3 + c + 1)));
            if (r == 0) a0 = acc_cyc; else a1 = acc_cyc;
        end
        in_valid = 1'b0;
        wait_done(base);
        check("s1_writes", 64'(got_addr.size()), 64'd2);
        check("s1_addr0", 64'(got_addr[0]), 64'd0);
        check("s1_data0", 64'(got_data[0]), 64'h11223300);
        check("s1_addr1", 64'(got_addr[1]), 64'd1);
        check("s1_data1", 64'(got_data[1]), 64'h44556600);
        check("s1_lat0", 64'(got_cyc[0]), 64'(a0 + 1));
        check("s1_lat1", 64'(got_cyc[1]), 64'(a1 + 1));
        check("s1_done_cycle", 64'(done_cyc), 64'(got_cyc[1] + 1));
        check("s1_err", 64'(err), 64'd0);
        check("s1_busy_after", 64'(busy), 64'd0);

        // Out-of-order columns 3,1,0,2 with A,B,C,D.
        clear_log();
        base = done_cnt;
        start_mat(4'd1, 3'd4);
        send(3'd0, 2'd3, 8'hAA);
        send(3'd0, 2'd1, 8'hBB);
        send(3'd0, 2'd0, 8'hCC);
        in_valid = 1'b0;
        tick();
        check("s2_no_early_write", 64'(got_addr.size()), 64'd0);
        send(3'd0, 2'd2, 8'hDD);
        in_valid = 1'b0;
        a0 = acc_cyc;
        wait_done(base);
        check("s2_data", 64'(got_data[0]), 64'hCCBBDDAA);
        check("s2_lat", 64'(got_cyc[0]), 64'(a0 + 1));

        // Duplicate column, wrong row and out-of-range column are dropped.
        clear_log();
        base = done_cnt;
        start_mat(4'd1, 3'd3);
        send(3'd0, 2'd1, 8'h21);
        send(3'd0, 2'd1, 8'h99);
        in_valid = 1'b0;
        check("s3_err_dup", 64'(err), 64'd1);
        send(3'd5, 2'd0, 8'h55);
        send(3'd0, 2'd3, 8'h77);
        send(3'd0, 2'd0, 8'h20);
        send(3'd0, 2'd2, 8'h22);
        in_valid = 1'b0;
        wait_done(base);
        check("s3_writes", 64'(got_addr.size()), 64'd1);
        check("s3_data", 64'(got_data[0]), 64'h20212200);
        check("s3_err_sticky", 64'(err), 64'd1);

        // in_valid held high across the row boundary.
        clear_log();
        base = done_cnt;
        start_mat(4'd2, 3'd2);
        send(3'd0, 2'd0, 8'h01);
        send(3'd0, 2'd1, 8'h02);
        send(3'd1, 2'd0, 8'h03);
        send(3'd1, 2'd1, 8'h04);
        in_valid = 1'b0;
        wait_done(base);
        check("s4_writes", 64'(got_addr.size()), 64'd2);
        check("s4_data0", 64'(got_data[0]), 64'h01020000);
        check("s4_data1", 64'(got_data[1]), 64'h03040000);
        check("s4_err", 64'(err), 64'd0);

        // Reset partway through a 4x2 load, then a fresh 1x1 load.
        clear_log();
        start_mat(4'd4, 3'd2);
        send(3'd0, 2'd0, 8'h10);
        send(3'd0, 2'd1, 8'h11);
        send(3'd1, 2'd0, 8'h12);
        send(3'd1, 2'd1, 8'h13);
        send(3'd7, 2'd0, 8'h66);
        send(3'd2, 2'd0, 8'h14);
        in_valid = 1'b0;
        check("s5_rows_before_rst", 64'(got_addr.size()), 64'd2);
        check("s5_err_before_rst", 64'(err), 64'd1);
        rst = 1'b1;
        tick();
        check("s5_outputs_after_rst",
              64'({in_ready, wr_en, busy, done, err, wr_addr, wr_data}), 64'd0);
        rst = 1'b0;
        clear_log();
        base = done_cnt;
        start_mat(4'd1, 3'd1);
        send(3'd0, 2'd0, 8'hFF);
        in_valid = 1'b0;
        wait_done(base);
        check("s5_writes", 64'(got_addr.size()), 64'd1);
        check("s5_addr", 64'(got_addr[0]), 64'd0);
        check("s5_data", 64'(got_data[0]), 64'hFF000000);
        check("s5_err", 64'(err), 64'd0);

        // Randomized loads: shuffled columns, idle gaps and injected bad elements.
        for (int it = 0; it < 40; it++) begin
            nr = $urandom_range(1, 8);
            nc = $urandom_range(1, 4);
            err_exp = 1'b0;
            clear_log();
            base = done_cnt;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 4; c++) m[r][c] = 8'($urandom);
            start_mat(4'(nr), 3'(nc));
            for (int r = 0; r < nr; r++) begin
                for (int c = 0; c < 4; c++) p[c] = c;
                for (int i = nc - 1; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    t = p[i];
                    p[i] = p[j];
                    p[j] = t;
                end
                inj = ($urandom_range(0, 3) == 0);
                pos = $urandom_range(0, nc - 1);
                for (int k = 0; k < nc; k++) begin
                    if (inj && k == pos) begin
                        kind = $urandom_range(0, 2);
                        if (kind == 2 && k == 0) kind = 0;
                        if (kind == 1 && nc == 4) kind = 0;
                        case (kind)
                            0: send(3'((r + 1 + $urandom_range(0, 6)) % 8), 2'($urandom), 8'($urandom));
                            1: send(3'(r), 2'($urandom_range(nc, 3)), 8'($urandom));
                            default: send(3'(r), 2'(p[$urandom_range(0, k - 1)]), 8'($urandom));
                        endcase
                        err_exp = 1'b1;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        tick();
                    end
                    send(3'(r), 2'(p[k]), m[r][p[k]]);
                end
            end
            in_valid = 1'b0;
            wait_done(base);
            check($sformatf("rnd%0d_writes", it), 64'(got_addr.size()), 64'(nr));
            for (int r = 0; r < nr; r++) begin
                exp_row = '0;
                for (int c = 0; c < MC; c++)
                    exp_row = {exp_row[DW-EW-1:0], (c < nc) ? m[r][c] : 8'h00};
                check($sformatf("rnd%0d_addr%0d", it, r), 64'(got_addr[r]), 64'(r));
                check($sformatf("rnd%0d_data%0d", it, r), 64'(got_data[r]), 64'(exp_row));
            end
            check($sformatf("rnd%0d_err", it), 64'(err), 64'(err_exp));
        end

        check("in_ready_low_in_flush", 64'(flush_ready_viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
